spi_slv16: RTL and testbench
============================

# spi_slv16

Sixteen-bit SPI responder that sits on the peripheral side of a 16-bit SPI master link. The protocol is mode 3: SCLK idles high, data is driven on the SCLK fall and sampled on the SCLK rise, MSB first, and SS_n is active-low framing. All SPI inputs are oversampled by the system clock. The block shifts a preloaded response word out on MISO while collecting the command word from MOSI, then presents the received word with a one-cycle ready strobe. It is used to model and bench-test peripherals such as ADCs and inertial sensors.

## Interface
- SYNC_FF, default 2: synchronizer depth for SS_n, SCLK and MOSI. Legal values are 2 or 3.
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- SS_n  input  1  slave select from the master, active-low.
- SCLK  input  1  serial clock from the master; idles high.
- MOSI  input  1  serial data from the master.
- MISO  output  1  serial data to the master; equals tx_shft[15].
- tx_data  input  16  response word; captured when the frame starts.
- rx_data  output  16  last complete received word.
- rdy  output  1  one-cycle pulse when rx_data updates.
- err  output  1  one-cycle pulse on a malformed frame. Present only with SPI_SLV16_ERR_EN.

## Operation
- Synchronizers: SS_n, SCLK and MOSI each pass through SYNC_FF flops, plus one extra flop on SS_n and SCLK for edge detection.
  - SCLK sync flops reset to 1.
  - SS_n and MOSI sync flops reset to 0. This prevents a false frame start when SS_n is already low while rst is asserted.
- Edge definitions, on synchronized values: fall = previous 1, current 0; rise = previous 0, current 1.
- IDLE state:
  - On SS_n fall: tx_shft <= tx_data, bit_cnt <= 0, armed <= 0, go to ACTIVE.
  - SCLK edges are ignored.
- ACTIVE state, SCLK rise:
  - smpl <= synced MOSI.
  - armed <= 1.
  - bit_cnt increments and saturates at 17.
- ACTIVE state, SCLK fall with armed = 1:
  - tx_shft <= {tx_shft[14:0], smpl}.
  - rx_shft is the same register, so after 16 rises the word holds the received command.
  - The master's leading SCLK fall, which arrives before the first rise, causes no shift because armed = 0.
- ACTIVE state, SS_n rise: go to IDLE.
  - If bit_cnt == 16: rx_data <= received word, rdy = 1.
  - If bit_cnt != 16: rx_data is unchanged, no rdy, and err = 1 when the error feature is compiled in.
- Received-word assembly: the word captured at the SS_n rise is {tx_shft[14:0], smpl} if the 16th-rise sample has not yet been shifted in, and tx_shft otherwise.
  - Implementations track this with a flag set on the 16th rise and cleared by the next fall.
- Reset values:
  - MISO 0, rx_data 16'h0000, rdy 0, err 0.
  - State IDLE, bit_cnt 0, tx_shft 0, armed 0.
- Reset mid-frame: the block returns to IDLE. The rest of that frame is ignored, because a new frame needs a fresh SS_n fall.

## Timing
- Edge detection latency: SYNC_FF+1 clk from the pin edge to the internal action.
- MISO bit 15 is valid SYNC_FF+2 clk after the SS_n pin falls.
- Each subsequent MISO bit is valid SYNC_FF+2 clk after the SCLK pin falls.
- Minimum SCLK half-period: SYNC_FF+3 clk. MOSI must be stable from SCLK fall through SYNC_FF+1 clk after SCLK rise.
- rdy (and err) assert SYNC_FF+2 clk after the SS_n pin rises. rx_data is valid in the same cycle as rdy and is held until the next good frame.
- Simultaneous SS_n rise and SCLK edge in the same cycle: the SS_n rise wins and the SCLK edge is dropped.
- tx_data may change freely except in the cycle the SS_n fall is detected.

## Configuration
- SPI_SLV16_ERR_EN defined:
  - The err port exists.
  - A frame ending with bit_cnt != 16 (short frame, or over-length frame with count 17) pulses err for 1 clk.
- SPI_SLV16_ERR_EN undefined:
  - No err port.
  - Malformed frames are silently discarded: no rdy and rx_data unchanged.

## Test plan
- Master sends cmd 16'hA5C3 with tx_data = 16'h1234 and 32-clk SCLK: rx_data = 16'hA5C3, rdy pulses once, and the master reads 16'h1234.
- Two back-to-back frames (16'h0001 then 16'hFFFE) with tx_data changed between frames: each rx_data and MISO word is correct, with exactly two rdy pulses.
- Frame aborted after 9 SCLK rises: no rdy, rx_data keeps its previous value, err pulses (with SPI_SLV16_ERR_EN).
- Frame with 17 SCLK rises: no rdy, err pulses.
- rst asserted mid-frame (bit 6) and released while SS_n is still low: no rdy, no err, outputs return to reset values. The next full frame 16'h8001 gives rx_data = 16'h8001.
- SYNC_FF = 3 with minimum SCLK half-period (6 clk), cmd 16'h5A5A: correct rx_data and MISO word.

Source files
------------

// File: rtl/spi_slv16.sv
// Mode-3 16-bit SPI responder, oversampled by clk: shifts tx_data out on MISO while collecting the command from MOSI.
// Define SPI_SLV16_ERR_EN to add the err port, which pulses on frames that do not end after exactly 16 SCLK rises.
module spi_slv16 #(
    parameter int SYNC_FF = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [15:0] tx_data,
    output logic [15:0] rx_data,
    output logic        rdy
`ifdef SPI_SLV16_ERR_EN
    ,
    output logic        err
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    generate
        if (SYNC_FF < 2 || SYNC_FF > 3) begin : g_bad_sync_ff
            $error("spi_slv16: SYNC_FF must be 2 or 3");
        end
    endgenerate

    logic [SYNC_FF-1:0] ss_sync;
    logic [SYNC_FF-1:0] sclk_sync;
    logic [SYNC_FF-1:0] mosi_sync;
    logic               ss_dly;
    logic               sclk_dly;

    logic ss_s;
    logic sclk_s;
    logic mosi_s;
    logic ss_fall;
    logic ss_rise;
    logic sclk_fall;
    logic sclk_rise;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  bit_cnt;
    logic [15:0] tx_shft;
    logic        smpl;
    logic        armed;
    logic        last_pend;
    logic        frame_start;
    logic        frame_end;
    logic        cnt_ok;
    logic [15:0] rx_word;

    // Synchronizer stage: SS_n/MOSI chains reset low so an SS_n held low through reset never looks like a fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_sync   <= '0;
            sclk_sync <= '1;
            mosi_sync <= '0;
            ss_dly    <= 1'b0;
            sclk_dly  <= 1'b1;
        end else begin
            ss_sync   <= {ss_sync[SYNC_FF-2:0], SS_n};
            sclk_sync <= {sclk_sync[SYNC_FF-2:0], SCLK};
            mosi_sync <= {mosi_sync[SYNC_FF-2:0], MOSI};
            ss_dly    <= ss_sync[SYNC_FF-1];
            sclk_dly  <= sclk_sync[SYNC_FF-1];
        end
    end

    // Edge-detect stage
    always_comb begin
        ss_s      = ss_sync[SYNC_FF-1];
        sclk_s    = sclk_sync[SYNC_FF-1];
        mosi_s    = mosi_sync[SYNC_FF-1];
        ss_fall   = ss_dly & ~ss_s;
        ss_rise   = ~ss_dly & ss_s;
        sclk_fall = sclk_dly & ~sclk_s;
        sclk_rise = ~sclk_dly & sclk_s;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall) begin
                    state_nxt   = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The 16th sample may still be waiting in smpl if the master did not issue a trailing fall.
    always_comb begin
        cnt_ok  = (bit_cnt == 5'd16);
        rx_word = last_pend ? {tx_shft[14:0], smpl} : tx_shft;
    end

    // Shift stage: SS_n rise takes priority over any SCLK edge in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= 5'd0;
            tx_shft   <= 16'h0000;
            smpl      <= 1'b0;
            armed     <= 1'b0;
            last_pend <= 1'b0;
        end else if (frame_start) begin
            bit_cnt   <= 5'd0;
            tx_shft   <= tx_data;
            armed     <= 1'b0;
            last_pend <= 1'b0;
        end else if (state == ACTIVE && !ss_rise) begin
            if (sclk_rise) begin
                smpl  <= mosi_s;
                armed <= 1'b1;
                if (bit_cnt != 5'd17) begin
                    bit_cnt <= bit_cnt + 5'd1;
                end
                if (bit_cnt == 5'd15) begin
                    last_pend <= 1'b1;
                end
            end else if (sclk_fall && armed) begin
                tx_shft   <= {tx_shft[14:0], smpl};
                last_pend <= 1'b0;
            end
        end
    end

    // Output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data <= 16'h0000;
            rdy     <= 1'b0;
        end else begin
            rdy <= 1'b0;
            if (frame_end && cnt_ok) begin
                rx_data <= rx_word;
                rdy     <= 1'b1;
            end
        end
    end

`ifdef SPI_SLV16_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= frame_end & ~cnt_ok;
        end
    end
`endif

    assign MISO = tx_shft[15];

endmodule

// File: tb/tb_spi_slv16.sv
// Directed bench for spi_slv16: two instances (SYNC_FF=2 and 3) driven by one bit-banged mode-3 master.
module tb_spi_slv16;

    logic        clk;
    logic        rst;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    logic [15:0] tx_data;
    logic        miso2, miso3;
    logic [15:0] rx2, rx3;
    logic        rdy2, rdy3;
    logic        err2, err3;

    int checks = 0;
    int errors = 0;
    int rdy_cnt2 = 0, rdy_cnt3 = 0;
    int err_cnt2 = 0, err_cnt3 = 0;

    spi_slv16 #(.SYNC_FF(2)) u_dut2 (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(miso2), .tx_data(tx_data), .rx_data(rx2), .rdy(rdy2)
`ifdef SPI_SLV16_ERR_EN
        , .err(err2)
`endif
    );

    spi_slv16 #(.SYNC_FF(3)) u_dut3 (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
        .MISO(miso3), .tx_data(tx_data), .rx_data(rx3), .rdy(rdy3)
`ifdef SPI_SLV16_ERR_EN
        , .err(err3)
`endif
    );

`ifndef SPI_SLV16_ERR_EN
    assign err2 = 1'b0;
    assign err3 = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rdy2) rdy_cnt2++;
        if (rdy3) rdy_cnt3++;
        if (err2) err_cnt2++;
        if (err3) err_cnt3++;
    end

    typedef struct {
        logic [15:0] cmd;
        logic [15:0] tx;
        int          nrises;
        int          half;
        logic [15:0] exp_rx;
        int          exp_rdy;
        int          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] cmd, input int nrises, input int half,
                              output logic [15:0] w2, output logic [15:0] w3);
        w2 = '0;
        w3 = '0;
        SS_n = 1'b0;
        wait_clk(half);
        for (int i = 0; i < nrises; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            wait_clk(half);
            if (i < 16) begin
                w2[15-i] = miso2;
                w3[15-i] = miso3;
            end
            SCLK = 1'b1;
            wait_clk(half);
        end
        SS_n = 1'b1;
        wait_clk(12);
    endtask

    initial begin
        logic [15:0] w2, w3;
        int r2, r3, e2, e3;

        vecs[0] = '{16'hA5C3, 16'h1234, 16, 16, 16'hA5C3, 1, 0};
        vecs[1] = '{16'h0001, 16'hBEEF, 16, 8,  16'h0001, 1, 0};
        vecs[2] = '{16'hFFFE, 16'h4321, 16, 8,  16'hFFFE, 1, 0};
        vecs[3] = '{16'h3C3C, 16'h0F0F, 9,  8,  16'hFFFE, 0, 1};
        vecs[4] = '{16'h7777, 16'hF00D, 17, 8,  16'hFFFE, 0, 1};
        vecs[5] = '{16'h5A5A, 16'hC3A5, 16, 6,  16'h5A5A, 1, 0};

        rst = 1'b1;
        SS_n = 1'b1;
        SCLK = 1'b1;
        MOSI = 1'b0;
        tx_data = 16'h0000;
        wait_clk(4);
        chk("reset_miso2", miso2, 1'b0);
        chk("reset_miso3", miso3, 1'b0);
        chk("reset_rx2", rx2, 16'h0000);
        chk("reset_rx3", rx3, 16'h0000);
        chk("reset_rdy2", rdy2, 1'b0);
        chk("reset_rdy3", rdy3, 1'b0);
        rst = 1'b0;
        wait_clk(8);
        chk("idle_rdy_count", rdy_cnt2 + rdy_cnt3, 0);

        for (int v = 0; v < 6; v++) begin
            tx_data = vecs[v].tx;
            wait_clk(2);
            r2 = rdy_cnt2; r3 = rdy_cnt3; e2 = err_cnt2; e3 = err_cnt3;
            send_frame(vecs[v].cmd, vecs[v].nrises, vecs[v].half, w2, w3);
            chk($sformatf("v%0d_rx2", v), rx2, vecs[v].exp_rx);
            chk($sformatf("v%0d_rx3", v), rx3, vecs[v].exp_rx);
            chk($sformatf("v%0d_rdy2", v), rdy_cnt2 - r2, vecs[v].exp_rdy);
            chk($sformatf("v%0d_rdy3", v), rdy_cnt3 - r3, vecs[v].exp_rdy);
            if (vecs[v].nrises >= 16) begin
                chk($sformatf("v%0d_miso2", v), w2, vecs[v].tx);
                chk($sformatf("v%0d_miso3", v), w3, vecs[v].tx);
            end
`ifdef SPI_SLV16_ERR_EN
            chk($sformatf("v%0d_err2", v), err_cnt2 - e2, vecs[v].exp_err);
            chk($sformatf("v%0d_err3", v), err_cnt3 - e3, vecs[v].exp_err);
`else
            chk($sformatf("v%0d_noerr", v), (err_cnt2 - e2) + (err_cnt3 - e3), 0);
`endif
        end
        chk("good_frames_rdy2", rdy_cnt2, 4);
        chk("good_frames_rdy3", rdy_cnt3, 4);

        // Reset during bit 6 of a frame, released with SS_n still low.
        tx_data = 16'hFFFF;
        wait_clk(2);
        r2 = rdy_cnt2; r3 = rdy_cnt3; e2 = err_cnt2; e3 = err_cnt3;
        SS_n = 1'b0;
        wait_clk(8);
        for (int i = 0; i < 6; i++) begin
            SCLK = 1'b0;
            MOSI = i[0];
            wait_clk(8);
            SCLK = 1'b1;
            wait_clk(8);
        end
        SCLK = 1'b0;
        wait_clk(3);
        rst = 1'b1;
        wait_clk(3);
        chk("midrst_miso2", miso2, 1'b0);
        chk("midrst_miso3", miso3, 1'b0);
        chk("midrst_rx2", rx2, 16'h0000);
        chk("midrst_rx3", rx3, 16'h0000);
        rst = 1'b0;
        wait_clk(6);
        SCLK = 1'b1;
        wait_clk(8);
        chk("after_rst_miso2", miso2, 1'b0);
        SS_n = 1'b1;
        wait_clk(12);
        chk("midrst_rdy", (rdy_cnt2 - r2) + (rdy_cnt3 - r3), 0);
        chk("midrst_err", (err_cnt2 - e2) + (err_cnt3 - e3), 0);
        chk("midrst_rx_hold2", rx2, 16'h0000);

        tx_data = 16'h00FF;
        wait_clk(2);
        r2 = rdy_cnt2;
        send_frame(16'h8001, 16, 8, w2, w3);
        chk("post_rst_rx2", rx2, 16'h8001);
        chk("post_rst_rx3", rx3, 16'h8001);
        chk("post_rst_rdy2", rdy_cnt2 - r2, 1);
        chk("post_rst_miso2", w2, 16'h00FF);
        chk("post_rst_miso3", w3, 16'h00FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
